// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcodes and arbiter state encoding
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_NOT = 3'b101;
  localparam logic [OP_W-1:0] ALU_SHL = 3'b110;
  localparam logic [OP_W-1:0] ALU_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, response and ALU signal bundle
interface alu_share_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
);
  import alu_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W*N_REQ-1:0] req_a;
  logic [DATA_W*N_REQ-1:0] req_b;
  logic [OP_W*N_REQ-1:0]   req_op;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_result;
  logic                    rsp_zero;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic [OP_W-1:0]         alu_op;
  logic [DATA_W-1:0]       alu_result;
  logic                    alu_zero;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_id,
           alu_a, alu_b, alu_op, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_id,
           alu_a, alu_b, alu_op, busy
  );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// rtl/alu_share_arbiter_rr_pick.sv - rotate-priority picker starting after i_last
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam int NP = 1 << IDX_W;

  logic [NP-1:0]  w_req_ext;
  logic [NP-1:0]  w_grant_ext;
  logic [IDX_W:0] w_pos;

  always_comb begin
    w_req_ext          = '0;
    w_req_ext[N-1:0]   = i_req;
    w_grant_ext        = '0;
    w_pos              = '0;
    o_idx              = '0;
    o_any              = 1'b0;
    // Visit last+1 .. last+N modulo N; the first requester seen wins.
    for (int k = 1; k <= N; k++) begin
      w_pos = {1'b0, i_last} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(N))
        w_pos = w_pos - (IDX_W+1)'(N);
      if (!o_any && w_req_ext[w_pos[IDX_W-1:0]]) begin
        o_any                          = 1'b1;
        o_idx                          = w_pos[IDX_W-1:0];
        w_grant_ext[w_pos[IDX_W-1:0]]  = 1'b1;
      end
    end
    o_grant = w_grant_ext[N-1:0];
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one external ALU among N_REQ requesters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave bus
);

  arb_state_t        r_state, w_next;
  logic [ID_W-1:0]   r_last, r_gid, w_pick_idx;
  logic [N_REQ-1:0]  w_pick_grant, w_own;
  logic              w_any, w_rsp_done;
  logic [DATA_W-1:0] r_alu_a, r_alu_b, r_result, w_sel_a, w_sel_b;
  logic [OP_W-1:0]   r_alu_op, w_sel_op;
  logic              r_zero;

  rr_pick #(.N(N_REQ), .IDX_W(ID_W)) u_pick (
    .i_req   (bus.req_valid),
    .i_last  (r_last),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    w_own    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_grant[i]) begin
        w_sel_a  = bus.req_a[i*DATA_W +: DATA_W];
        w_sel_b  = bus.req_b[i*DATA_W +: DATA_W];
        w_sel_op = bus.req_op[i*OP_W +: OP_W];
      end
      w_own[i] = (r_gid == ID_W'(i));
    end
  end

  assign w_rsp_done = (r_state == ST_RESP) && (|(bus.rsp_ready & w_own));

  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        // Gated by rst so nothing looks accepted while reset is held.
        if (!rst)
          bus.req_ready = w_pick_grant;
        if (w_any)
          w_next = ST_EXEC;
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid = w_own;
        if (w_rsp_done)
          w_next = ST_IDLE;
      end
      default: begin
        bus.busy = 1'b0;
        w_next   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last   <= ID_W'(N_REQ - 1);
      r_gid    <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
        r_alu_op <= w_sel_op;
        r_gid    <= w_pick_idx;
      end
      if (r_state == ST_EXEC) begin
        r_result <= bus.alu_result;
        r_zero   <= bus.alu_zero;
      end
      if (w_rsp_done)
        r_last <= r_gid;
    end
  end

  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_op     = r_alu_op;
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign bus.rsp_id     = r_gid;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed bench with result scoreboard for alu_share_arbiter
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.N_REQ(2), .ID_W(1)) bus_if ();

  alu_share_arbiter #(.N_REQ(2), .ID_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOT: return ~a;
      ALU_SHL: return {a[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction

  // External ALU stand-in.
  assign bus_if.alu_result = alu_f(bus_if.alu_a, bus_if.alu_b, bus_if.alu_op);
  assign bus_if.alu_zero   = (bus_if.alu_result == 8'h00);

  typedef struct {
    logic [0:0] id;
    logic [7:0] res;
    logic       zero;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   cyc_log[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on acceptance, pop and compare on response handshake.
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus_if.req_valid[i] && bus_if.req_ready[i]) begin
          e.id   = 1'(i);
          e.res  = alu_f(bus_if.req_a[i*8 +: 8], bus_if.req_b[i*8 +: 8], bus_if.req_op[i*3 +: 3]);
          e.zero = (e.res == 8'h00);
          sb.push_back(e);
          grant_log.push_back(i);
          cyc_log.push_back(cyc);
        end
      end
      if ((bus_if.rsp_valid & bus_if.rsp_ready) != 2'b00) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow got=%0d exp=1", sb.size());
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_id", 32'(bus_if.rsp_id), 32'(e.id));
          chk("sb_result", 32'(bus_if.rsp_result), 32'(e.res));
          chk("sb_zero", 32'(bus_if.rsp_zero), 32'(e.zero));
          chk("sb_valid_onehot", 32'(bus_if.rsp_valid), 32'(1) << e.id);
        end
      end
    end
  end

  task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op);
    bus_if.req_a[id*8 +: 8]  = a;
    bus_if.req_b[id*8 +: 8]  = b;
    bus_if.req_op[id*3 +: 3] = op;
    bus_if.req_valid[id]     = 1'b1;
  endtask

  task automatic wait_ready(input int id, input string tag, output int waited);
    waited = 0;
    @(negedge clk);
    while (bus_if.req_ready[id] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready"}, 32'(bus_if.req_ready[id]), 32'd1);
  endtask

  task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] exp_res,
                         input logic exp_zero, input string tag);
    int w;
    drive(id, a, b, op);
    wait_ready(id, tag, w);
    chk({tag, "_same_cycle"}, 32'(w), 32'd0);
    chk({tag, "_ready_vec"}, 32'(bus_if.req_ready), 32'(1) << id);
    @(posedge clk); #1;
    bus_if.req_valid[id] = 1'b0;
    @(negedge clk);
    chk({tag, "_exec_no_rsp"}, 32'(bus_if.rsp_valid), 32'd0);
    chk({tag, "_exec_busy"}, 32'(bus_if.busy), 32'd1);
    chk({tag, "_alu_a"}, 32'(bus_if.alu_a), 32'(a));
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'(1) << id);
    chk({tag, "_result"}, 32'(bus_if.rsp_result), 32'(exp_res));
    chk({tag, "_zero"}, 32'(bus_if.rsp_zero), 32'(exp_zero));
    chk({tag, "_id"}, 32'(bus_if.rsp_id), 32'(id));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    int w;
    bus_if.req_valid = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.req_op    = '0;
    bus_if.rsp_ready = 2'b11;

    @(negedge clk);
    chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_alu_a", 32'(bus_if.alu_a), 32'd0);
    chk("rst_result", 32'(bus_if.rsp_result), 32'd0);
    chk("rst_id", 32'(bus_if.rsp_id), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_one(0, 8'h0F, 8'h01, ALU_ADD, 8'h10, 1'b0, "req0_add");
    run_one(1, 8'h55, 8'h55, ALU_SUB, 8'h00, 1'b1, "req1_sub");

    // Both requesters valid continuously: strict alternation, 3-cycle spacing.
    grant_log.delete();
    cyc_log.delete();
    drive(0, 8'h20, 8'h03, ALU_ADD);
    drive(1, 8'h20, 8'h03, ALU_SUB);
    n   = 0;
    acc = 0;
    while (acc < 6 && n < 60) begin
      @(negedge clk);
      n++;
      if ((bus_if.req_ready & bus_if.req_valid) != 2'b00) acc++;
    end
    @(posedge clk); #1;
    bus_if.req_valid = 2'b00;
    repeat (4) begin @(posedge clk); #1; end
    chk("rr_accept_count", 32'(acc), 32'd6);
    chk("rr_log_size", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) begin
        chk("rr_order", 32'(grant_log[k]), 32'(k % 2));
        if (k > 0) chk("rr_spacing", 32'(cyc_log[k] - cyc_log[k-1]), 32'd3);
      end
    end

    // Back-pressure: owner's rsp_ready low, non-owner's high (ignored).
    bus_if.rsp_ready = 2'b00;
    drive(0, 8'hFF, 8'h01, ALU_ADD);
    wait_ready(0, "bp", w);
    @(posedge clk); #1;
    bus_if.req_valid[0] = 1'b0;
    drive(1, 8'h11, 8'h22, ALU_OR);
    bus_if.rsp_ready = 2'b10;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      chk("bp_result", 32'(bus_if.rsp_result), 32'h00);
      chk("bp_zero", 32'(bus_if.rsp_zero), 32'd1);
      chk("bp_req_ready", 32'(bus_if.req_ready), 32'd0);
      chk("bp_busy", 32'(bus_if.busy), 32'd1);
    end
    @(posedge clk); #1;
    bus_if.rsp_ready    = 2'b11;
    bus_if.req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp_pending", 32'(bus_if.rsp_valid), 32'd1);
    @(posedge clk); #1;
    chk("bp_done_busy", 32'(bus_if.busy), 32'd0);
    chk("bp_done_valid", 32'(bus_if.rsp_valid), 32'd0);

    run_one(1, 8'h81, 8'h00, ALU_SHL, 8'h02, 1'b0, "shl");
    run_one(0, 8'h81, 8'h00, ALU_SHR, 8'h40, 1'b0, "shr");
    run_one(1, 8'hF0, 8'h00, ALU_NOT, 8'h0F, 1'b0, "not");

    // Reset while req1's operation is in EXEC.
    drive(1, 8'h33, 8'h44, ALU_ADD);
    wait_ready(1, "rst_mid", w);
    @(posedge clk); #1;
    chk("rst_mid_exec_busy", 32'(bus_if.busy), 32'd1);
    chk("rst_mid_exec_alu_a", 32'(bus_if.alu_a), 32'h33);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_mid_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(bus_if.req_ready), 32'd0);
    chk("rst_mid_alu_a", 32'(bus_if.alu_a), 32'd0);
    chk("rst_mid_alu_b", 32'(bus_if.alu_b), 32'd0);
    chk("rst_mid_alu_op", 32'(bus_if.alu_op), 32'd0);
    chk("rst_mid_result", 32'(bus_if.rsp_result), 32'd0);
    chk("rst_mid_zero", 32'(bus_if.rsp_zero), 32'd0);
    chk("rst_mid_id", 32'(bus_if.rsp_id), 32'd0);
    drive(0, 8'h01, 8'h02, ALU_ADD);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_grant", 32'(bus_if.req_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.req_valid = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
